// File: rtl/spi_master_gen.sv
// SPI master: one DATA_W word per start request, all CPOL/CPHA modes, MSB/LSB order, SCLK divider, abort.
// Optional feature macro: SPI_LOOPBACK_EN (latched loopback routes internal mosi into the RX sampler).
module spi_master_gen #(
    parameter int  DATA_W   = 8,
    parameter int  NUM_SS   = 4,
    parameter int  DIV_W    = 8,
    localparam int SS_IDX_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic                clk,
    input  logic                presetn,
    input  logic                start_i,
    input  logic [DATA_W-1:0]   tx_data_i,
    input  logic [SS_IDX_W-1:0] ss_sel_i,
    input  logic                cpol_i,
    input  logic                cpha_i,
    input  logic                lsb_first_i,
    input  logic [DIV_W-1:0]    clk_div_i,
    input  logic                abort_i,
    input  logic                loopback_i,
    input  logic                miso_i,
    output logic                sclk_o,
    output logic                mosi_o,
    output logic [NUM_SS-1:0]   ss_n_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [DATA_W-1:0]   rx_data_o
);
    localparam int EC_W = $clog2(2*DATA_W + 1);
    localparam int BI_W = $clog2(DATA_W);
    localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2*DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      cnt_q, cnt_d, div_q, div_d;
    logic [EC_W-1:0]       edge_q, edge_d;
    logic [DATA_W-1:0]     tx_q, tx_d, rxsh_q, rxsh_d, rx_q, rx_d;
    logic [SS_IDX_W-1:0]   ss_q, ss_d;
    logic                  cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic                  sclk_q, sclk_d, mosi_q, mosi_d, done_q, done_d;
    logic                  tick, rx_bit, active;

    // Edge count e maps to word bit e/2: both sampling edges and the cpha=1 shift use edge_q,
    // the cpha=0 shift (after a trailing edge) looks one edge ahead.
    function automatic logic [BI_W-1:0] bit_pos(input logic [EC_W-1:0] e, input logic lsb);
        logic [BI_W-1:0] k;
        k = BI_W'(e >> 1);
        return lsb ? k : BI_W'(DATA_W - 1) - k;
    endfunction

`ifdef SPI_LOOPBACK_EN
    logic lb_q, lb_d;
    assign rx_bit = lb_q ? mosi_q : miso_i;
`else
    logic unused_loopback;
    assign unused_loopback = loopback_i;
    assign rx_bit          = miso_i;
`endif

    assign tick   = (cnt_q == div_q);
    assign active = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == IDLE || tick) ? '0 : cnt_q + DIV_W'(1);
        div_d   = div_q;
        edge_d  = edge_q;
        tx_d    = tx_q;
        rxsh_d  = rxsh_q;
        rx_d    = rx_q;
        ss_d    = ss_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        lsb_d   = lsb_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        done_d  = 1'b0;
`ifdef SPI_LOOPBACK_EN
        lb_d    = lb_q;
`endif
        if (abort_i) begin
            state_d = IDLE;
            sclk_d  = cpol_q;
            mosi_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    sclk_d = cpol_i;
                    mosi_d = 1'b0;
                    // done_q marks the completion cycle, where a new start is not accepted
                    if (start_i && !done_q) begin
                        state_d = SETUP;
                        div_d   = clk_div_i;
                        tx_d    = tx_data_i;
                        ss_d    = ss_sel_i;
                        cpol_d  = cpol_i;
                        cpha_d  = cpha_i;
                        lsb_d   = lsb_first_i;
                        edge_d  = '0;
                        rxsh_d  = '0;
                        mosi_d  = cpha_i ? 1'b0 : tx_data_i[bit_pos('0, lsb_first_i)];
`ifdef SPI_LOOPBACK_EN
                        lb_d    = loopback_i;
`endif
                    end
                end
                SETUP: if (tick) state_d = XFER;
                XFER: if (tick) begin
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + EC_W'(1);
                    // even edge_q: upcoming edge is leading
                    if (~edge_q[0] ^ cpha_q)
                        rxsh_d[bit_pos(edge_q, lsb_q)] = rx_bit;
                    else if (cpha_q)
                        mosi_d = tx_q[bit_pos(edge_q, lsb_q)];
                    else if (edge_q != LAST_EDGE)
                        mosi_d = tx_q[bit_pos(edge_q + EC_W'(1), lsb_q)];
                    if (edge_q == LAST_EDGE) state_d = HOLD;
                end
                HOLD: if (tick) begin
                    state_d = IDLE;
                    rx_d    = rxsh_q;
                    done_d  = 1'b1;
                    mosi_d  = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            edge_q  <= '0;
            tx_q    <= '0;
            rxsh_q  <= '0;
            rx_q    <= '0;
            ss_q    <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SPI_LOOPBACK_EN
            lb_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            edge_q  <= edge_d;
            tx_q    <= tx_d;
            rxsh_q  <= rxsh_d;
            rx_q    <= rx_d;
            ss_q    <= ss_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            lsb_q   <= lsb_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
`ifdef SPI_LOOPBACK_EN
            lb_q    <= lb_d;
`endif
        end
    end

    // out-of-range ss_q shifts the one-hot out entirely, leaving every select high
    assign ss_n_o    = active ? ~(NUM_SS'(1) << ss_q) : '1;
    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;
    assign busy_o    = active;
    assign done_o    = done_q;
    assign rx_data_o = rx_q;
endmodule

// File: tb/tb_spi_master_gen.sv
// Bench for spi_master_gen: behavioural SPI slave on sclk edges, fixed and randomized transfers.
module tb_spi_master_gen;
    localparam int W = 8;

    logic       clk = 1'b0, presetn = 1'b0;
    logic       start = 1'b0, cpol = 1'b0, cpha = 1'b0, lsb = 1'b0;
    logic       abort = 1'b0, loopback = 1'b0, miso = 1'b0;
    logic [7:0] tx = '0, div = '0;
    logic [1:0] ss_sel = '0;
    logic       sclk, mosi, busy, done, sclk3, mosi3, busy3, done3;
    logic [3:0] ss_n;
    logic [2:0] ss3_n;
    logic [7:0] rx_data, rx3;

    int n_chk = 0, n_err = 0;

    // slave model state
    logic       s_active = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0;
    int         s_cnt = 0;
    logic [7:0] s_word = '0, m_word = '0;

    always #5 clk = ~clk;

    spi_master_gen #(.DATA_W(8), .NUM_SS(4), .DIV_W(8)) u_dut (
        .clk(clk), .presetn(presetn), .start_i(start), .tx_data_i(tx), .ss_sel_i(ss_sel),
        .cpol_i(cpol), .cpha_i(cpha), .lsb_first_i(lsb), .clk_div_i(div), .abort_i(abort),
        .loopback_i(loopback), .miso_i(miso), .sclk_o(sclk), .mosi_o(mosi), .ss_n_o(ss_n),
        .busy_o(busy), .done_o(done), .rx_data_o(rx_data));

    // three selects: index 3 is out of range here
    spi_master_gen #(.DATA_W(8), .NUM_SS(3), .DIV_W(8)) u_dut3 (
        .clk(clk), .presetn(presetn), .start_i(start), .tx_data_i(tx), .ss_sel_i(ss_sel),
        .cpol_i(cpol), .cpha_i(cpha), .lsb_first_i(lsb), .clk_div_i(div), .abort_i(abort),
        .loopback_i(loopback), .miso_i(miso), .sclk_o(sclk3), .mosi_o(mosi3), .ss_n_o(ss3_n),
        .busy_o(busy3), .done_o(done3), .rx_data_o(rx3));

    function automatic int bpos(input int k, input logic l);
        return l ? k : W - 1 - k;
    endfunction

    // Slave: odd edge counts are leading edges; sample on leading for cpha=0, trailing for cpha=1
    always @(sclk) begin
        if (s_active) begin
            s_cnt = s_cnt + 1;
            if (s_cnt[0] ^ s_cpha) begin
                m_word[bpos((s_cnt - 1) / 2, s_lsb)] = mosi;
            end else begin
                int k;
                k = s_cpha ? (s_cnt - 1) / 2 : s_cnt / 2;
                if (k < W) miso = s_word[bpos(k, s_lsb)];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic arm(input logic [7:0] tx_v, input logic [7:0] sw, input logic [1:0] ss_v,
                       input logic cpol_v, input logic cpha_v, input logic lsb_v,
                       input logic [7:0] div_v, input logic lb_v);
        @(negedge clk);
        tx = tx_v; ss_sel = ss_v; cpol = cpol_v; cpha = cpha_v; lsb = lsb_v;
        div = div_v; loopback = lb_v;
        @(negedge clk);
        s_word = sw; s_cpha = cpha_v; s_lsb = lsb_v; s_cnt = 0; m_word = '0;
        miso = sw[bpos(0, lsb_v)];
        s_active = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input string tag, input logic [7:0] tx_v, input logic [7:0] sw,
                       input logic [1:0] ss_v, input logic cpol_v, input logic cpha_v,
                       input logic lsb_v, input logic [7:0] div_v, input logic lb_v,
                       input logic [7:0] exp_rx, input logic poke, input logic use3);
        int n;
        logic ss_bad, ss3_bad;
        logic [3:0] exp_ss;
        exp_ss = ~(4'b0001 << ss_v);
        arm(tx_v, sw, ss_v, cpol_v, cpha_v, lsb_v, div_v, lb_v);
        n = 1; ss_bad = 1'b0; ss3_bad = 1'b0;
        check({tag, "_busy_rise"}, busy, 1);
        while (!done && n < 2000) begin
            if (ss_n !== exp_ss) ss_bad = 1'b1;
            if (ss3_n !== 3'b111) ss3_bad = 1'b1;
            start = poke && (n == 10);
            if (start) tx = ~tx_v;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        s_active = 1'b0;
        check({tag, "_latency"}, n, (int'(div_v) + 1) * (2 * W + 2) + 1);
        check({tag, "_rx"}, rx_data, exp_rx);
        check({tag, "_mosi_word"}, m_word, tx_v);
        check({tag, "_edges"}, s_cnt, 2 * W);
        check({tag, "_ss_n_xfer"}, ss_bad, 0);
        check({tag, "_ss_n_idle"}, ss_n, 4'hf);
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_sclk_idle"}, sclk, cpol_v);
        check({tag, "_mosi_idle"}, mosi, 0);
        if (use3) begin
            check({tag, "_ss3_oor"}, ss3_bad, 0);
            check({tag, "_done3"}, done3, 1);
            check({tag, "_rx3"}, rx3, exp_rx);
        end
        if (poke) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check({tag, "_start_in_done"}, busy, 0);
        end
    endtask

    initial begin
        int n;
        logic seen;
        logic [7:0] t, s;
        logic [1:0] sv;
        logic a, b, c;
        tx = 8'h00;
        #1;
        check("reset_sclk", sclk, 0);
        check("reset_ss_n", ss_n, 4'hf);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rx", rx_data, 0);
        repeat (3) @(negedge clk);
        presetn = 1'b1;

        run("mode0_a5", 8'hA5, 8'h3C, 2'd2, 0, 0, 0, 8'd1, 0, 8'h3C, 1'b1, 1'b0);
        run("mode1_81", 8'h81, 8'hC6, 2'd0, 0, 1, 1, 8'd0, 0, 8'hC6, 1'b0, 1'b0);
        run("mode2_81", 8'h81, 8'h35, 2'd1, 1, 0, 1, 8'd0, 0, 8'h35, 1'b0, 1'b0);
        run("mode3_81", 8'h81, 8'h9E, 2'd3, 1, 1, 1, 8'd0, 0, 8'h9E, 1'b0, 1'b0);

        // abort at edge 5: select drops next cycle, no done, rx_data holds 9E
        arm(8'hA5, 8'hF0, 2'd2, 0, 0, 0, 8'd1, 0);
        n = 0;
        while (s_cnt < 5 && n < 500) begin @(negedge clk); n++; end
        check("abort_edge5", s_cnt, 5);
        s_active = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ss_n", ss_n, 4'hf);
        check("abort_busy", busy, 0);
        check("abort_sclk", sclk, 0);
        check("abort_mosi", mosi, 0);
        seen = 1'b0;
        repeat (60) begin @(negedge clk); if (done) seen = 1'b1; end
        check("abort_no_done", seen, 0);
        check("abort_rx_hold", rx_data, 8'h9E);

        // start and abort together in IDLE
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", busy, 0);
        @(negedge clk);
        check("start_abort_busy2", busy, 0);

        // index 3 is out of range for the 3-select instance
        run("ss_oor", 8'h3B, 8'h6D, 2'd3, 0, 1, 0, 8'd2, 0, 8'h6D, 1'b0, 1'b1);

`ifdef SPI_LOOPBACK_EN
        run("loopback", 8'h5A, 8'h00, 2'd0, 0, 0, 0, 8'd1, 1, 8'h5A, 1'b0, 1'b0);
`else
        run("loopback", 8'h5A, 8'h00, 2'd0, 0, 0, 0, 8'd1, 1, 8'h00, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 12; i++) begin
            t = 8'($urandom); s = 8'($urandom); sv = 2'($urandom_range(0, 3));
            a = 1'($urandom); b = 1'($urandom); c = 1'($urandom);
            run($sformatf("rand%0d", i), t, s, sv, a, b, c, 8'($urandom_range(0, 3)), 0, s,
                1'($urandom), 1'b0);
        end

        // reset mid-transfer
        arm(8'hC3, 8'h55, 2'd1, 1, 0, 0, 8'd2, 0);
        n = 0;
        while (s_cnt < 3 && n < 500) begin @(negedge clk); n++; end
        check("rst_mid_edge3", s_cnt, 3);
        s_active = 1'b0;
        presetn = 1'b0;
        #1;
        check("rst_mid_sclk", sclk, 0);
        check("rst_mid_ss_n", ss_n, 4'hf);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_rx", rx_data, 0);
        @(negedge clk);
        presetn = 1'b1;
        run("post_rst", 8'h96, 8'h4B, 2'd0, 0, 0, 1, 8'd1, 0, 8'h4B, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
